tiny_dnn_axis_tx: RTL and testbench
===================================

// Module: tiny_dnn_axis_tx
// PURPOSE
//  AXI4-Stream master transmitter that feeds the accelerator's stream slave port
//  (S_AXIS_*) with weight, bias and source words.
//  - Buffers 16-bit values pushed by a local producer in a FIFO.
//  - Sends each value as one 32-bit beat, value in TDATA[31:16].
//  - Asserts TLAST on the final beat of a programmed-length packet.
//  - Sits between the producer (test/DMA side) and the accelerator top.
// PARAMETERS
//  DEPTH   16  FIFO depth in 16-bit entries; power of two, >= 2.
//  LEN_W   12  Packet length counter width (matches the ss/ds length field width).
// PORTS
//  AXIS_ACLK      in   1      Clock.
//  AXIS_ARESETN   in   1      Reset, asynchronous, active-low.
//  clr            in   1      Synchronous abort: flushes the FIFO and returns to IDLE.
//  start          in   1      One-cycle pulse that begins a packet.
//  len            in   LEN_W  Packet length in beats; sampled on start.
//  in_valid       in   1      Producer word valid.
//  in_data        in   16     Producer word.
//  in_ready       out  1      FIFO not full.
//  busy           out  1      Packet in progress.
//  done           out  1      One-cycle pulse at packet completion.
//  M_AXIS_TVALID  out  1      Stream beat valid.
//  M_AXIS_TDATA   out  32     {word, 16'h0000}.
//  M_AXIS_TSTRB   out  4      {4{M_AXIS_TVALID}}.
//  M_AXIS_TLAST   out  1      Final beat of the packet.
//  M_AXIS_TREADY  in   1      Downstream accept.
// BEHAVIOUR
//  Reset values: in_ready=1, busy=0, done=0, TVALID=0, TLAST=0, TDATA=0.
//   FIFO empty, remaining count=0, state=IDLE.
//  push = in_valid & in_ready. beat = TVALID & TREADY.
//   A push is accepted in any state, including IDLE (pre-fill is allowed).
//  FIFO:
//   - Full when it holds DEPTH entries; then in_ready=0.
//   - Pointers are LOG2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   - Push and pop in the same cycle while full: the pop frees a slot and the push
//     is accepted only if in_ready was already 1 that cycle.
//  FSM states:
//   - IDLE: on start & len!=0, load rem=len and go to SEND.
//     On start & len==0, pulse done next cycle, send no beats, stay in IDLE.
//   - SEND: TVALID = ~empty. TDATA = {head, 16'h0}. TLAST = (rem==1).
//     On each beat: pop the FIFO and decrement rem.
//     On the beat with rem==1: go to IDLE and pulse done in the following cycle.
//  start while busy is ignored; len is not re-sampled.
//  AXI-Stream rules:
//   - Once TVALID=1, TVALID, TDATA and TLAST hold until the beat completes.
//   - TVALID never depends combinationally on TREADY.
//   - Zero-bubble throughput: 1 beat/cycle while the FIFO is non-empty and TREADY=1.
//  Latency: a word pushed into an empty FIFO in SEND is on TDATA the next cycle.
//  busy = (state==SEND).
//  clr:
//   - Highest priority over start, push and beat in the same cycle.
//   - Next cycle: FIFO empty, IDLE, TVALID=0, rem=0; no done pulse.
//   - A beat in flight is abandoned. Callers pair clr with a downstream reset.
//  Async reset mid-packet: all outputs return to reset values immediately.
//  Words left in the FIFO after a packet completes remain there for the next packet.
// STRUCTURE
//  Shared package tiny_dnn_pkg:
//   - AXIS_DW=32, VAL_W=16, LEN_W=12.
//   - State encoding localparams ST_IDLE, ST_SEND.
//  Sub-module tiny_dnn_fifo: single-clock FIFO, registered storage, with
//   push/pop/full/empty/head ports. Reused later by the receive side.
//  Top of this block: FSM, rem counter, done/TLAST generation.
// TESTING
//  1. Pre-fill 4 words 0x3C00..0x3C03; start len=4; TREADY=1.
//     -> 4 consecutive beats, TDATA=0x3C000000..0x3C030000, TLAST on beat 4,
//        done 1 cycle later, busy 0.
//  2. start len=3 with empty FIFO; push 1 word every 3rd cycle.
//     -> TVALID only while data present, 3 beats, TLAST on the 3rd only.
//  3. len=5; TREADY toggles randomly.
//     -> TDATA/TLAST stable while TVALID&~TREADY; exactly 5 beats, in order.
//  4. Push 17 words with TREADY=0, DEPTH=16.
//     -> in_ready=0 after 16 pushes; the 17th is held by the producer until a pop.
//  5. start len=0 -> done pulse, no TVALID.
//     start during SEND -> ignored, beat count unchanged.
//  6. clr after beat 2 of len=8 -> TVALID=0 next cycle, FIFO empty, no done.
//     AXIS_ARESETN low mid-packet -> reset values immediately.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared definitions for the tiny_dnn stream interface blocks.
package tiny_dnn_pkg;
    localparam int AXIS_DW = 32;
    localparam int VAL_W   = 16;
    localparam int LEN_W   = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;
endpackage

// File: rtl/tiny_dnn_fifo.sv
// Single-clock FIFO with registered storage and a combinational head-of-queue view.
module tiny_dnn_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/tiny_dnn_axis_tx.sv
// AXI4-Stream master: FIFO-buffered 16-bit words sent as 32-bit beats in
// programmed-length packets with TLAST and a completion pulse.
module tiny_dnn_axis_tx #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 12
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESETN,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             M_AXIS_TVALID,
    output logic [31:0]      M_AXIS_TDATA,
    output logic [3:0]       M_AXIS_TSTRB,
    output logic             M_AXIS_TLAST,
    input  logic             M_AXIS_TREADY
);
    import tiny_dnn_pkg::*;

    state_t             state;
    logic [LEN_W-1:0]   rem;
    logic               done_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [VAL_W-1:0]   head;
    logic               push;
    logic               tvalid;
    logic               beat;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    // TVALID comes only from registered state, never from TREADY.
    assign tvalid   = (state == ST_SEND) & ~fifo_empty;
    assign beat     = tvalid & M_AXIS_TREADY;

    tiny_dnn_fifo #(
        .DEPTH (DEPTH),
        .W     (VAL_W)
    ) u_fifo (
        .clk   (AXIS_ACLK),
        .rst_n (AXIS_ARESETN),
        .clr   (clr),
        .push  (push),
        .pop   (beat),
        .din   (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state  <= ST_IDLE;
            rem    <= '0;
            done_q <= 1'b0;
        end else if (clr) begin
            state  <= ST_IDLE;
            rem    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            rem   <= len;
                            state <= ST_SEND;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (beat) begin
                        rem <= rem - 1'b1;
                        if (rem == LEN_W'(1)) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state == ST_SEND);
    assign done          = done_q;
    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = tvalid ? {head, {(AXIS_DW-VAL_W){1'b0}}} : '0;
    assign M_AXIS_TSTRB  = {4{tvalid}};
    assign M_AXIS_TLAST  = tvalid & (rem == LEN_W'(1));
endmodule

// File: tb/tb_tiny_dnn_axis_tx.sv
// Directed bench for tiny_dnn_axis_tx: packet framing, backpressure, FIFO full, clr and reset.
module tb_tiny_dnn_axis_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [11:0] len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;

    int          tests = 0;
    int          fails = 0;
    int          idx;
    logic [15:0] pat = 16'b0110_1001_1100_1010;
    logic [15:0] w;

    always #5 clk = ~clk;

    tiny_dnn_axis_tx #(.DEPTH(16), .LEN_W(12)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .clr           (clr),
        .start         (start),
        .len           (len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 1: pre-filled packet at full rate
        for (int i = 0; i < 4; i++) push_word(16'h3C00 + 16'(i));
        tready = 1'b1;
        start = 1'b1; len = 12'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 16'h3C00 + 16'(i);
            chk("t1_tvalid", tvalid, 1);
            chk("t1_tdata", tdata, {w, 16'h0000});
            chk("t1_tstrb", tstrb, 4'hF);
            chk("t1_tlast", tlast, (i == 3));
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_tvalid_end", tvalid, 0);
        tick();
        chk("t1_done_clear", done, 0);

        // 2: empty FIFO, one word every third cycle
        start = 1'b1; len = 12'd3;
        tick();
        start = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_tvalid_empty", tvalid, 0);
        for (int k = 0; k < 3; k++) begin
            w = 16'hA000 + 16'(k);
            push_word(w);
            chk("t2_tvalid", tvalid, 1);
            chk("t2_tdata", tdata, {w, 16'h0000});
            chk("t2_tlast", tlast, (k == 2));
            tick();
            if (k < 2) begin
                chk("t2_gap_tvalid", tvalid, 0);
                chk("t2_gap_tlast", tlast, 0);
                tick();
            end else begin
                chk("t2_done", done, 1);
                chk("t2_busy_end", busy, 0);
            end
        end
        tick();

        // 3: len=5 under irregular TREADY
        tready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'hB000 + 16'(i));
        start = 1'b1; len = 12'd5;
        tick();
        start = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            tready = pat[c % 16];
            #1;
            chk("t3_tvalid", tvalid, 1);
            w = 16'hB000 + 16'(idx);
            chk("t3_tdata", tdata, {w, 16'h0000});
            chk("t3_tlast", tlast, (idx == 4));
            if (tvalid && tready) idx++;
            tick();
        end
        chk("t3_beats", idx, 5);
        chk("t3_done", done, 1);
        chk("t3_tvalid_end", tvalid, 0);

        // 4: fill to DEPTH with TREADY low, 17th word waits for a pop
        tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_word(16'hC000 + 16'(i));
            chk("t4_in_ready", in_ready, (i < 15));
        end
        in_valid = 1'b1; in_data = 16'hC010;
        start = 1'b1; len = 12'd17;
        tick();
        start = 1'b0;
        chk("t4_held", in_ready, 0);
        chk("t4_head", tdata, 32'hC000_0000);
        tready = 1'b1;
        tick();
        chk("t4_slot_freed", in_ready, 1);
        chk("t4_beat1", tdata, 32'hC001_0000);
        tick();
        in_valid = 1'b0;
        for (int i = 2; i < 17; i++) begin
            w = 16'hC000 + 16'(i);
            chk("t4_tvalid", tvalid, 1);
            chk("t4_tdata", tdata, {w, 16'h0000});
            chk("t4_tlast", tlast, (i == 16));
            tick();
        end
        chk("t4_done", done, 1);
        chk("t4_tvalid_end", tvalid, 0);

        // 5: zero-length packet, then start while busy
        start = 1'b1; len = 12'd0;
        tick();
        start = 1'b0;
        chk("t5_len0_done", done, 1);
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_tvalid", tvalid, 0);
        tick();
        chk("t5_len0_done_clear", done, 0);
        for (int i = 0; i < 3; i++) push_word(16'hD000 + 16'(i));
        start = 1'b1; len = 12'd2;
        tick();
        chk("t5_first", tdata, 32'hD000_0000);
        chk("t5_first_last", tlast, 0);
        len = 12'd7;
        tick();
        start = 1'b0;
        chk("t5_ign_busy", busy, 1);
        chk("t5_ign_tdata", tdata, 32'hD001_0000);
        chk("t5_ign_tlast", tlast, 1);
        tick();
        chk("t5_ign_done", done, 1);
        chk("t5_ign_tvalid", tvalid, 0);

        // 6: clr mid-packet, then async reset mid-packet
        for (int i = 0; i < 7; i++) push_word(16'hE000 + 16'(i));
        start = 1'b1; len = 12'd8;
        tick();
        start = 1'b0;
        chk("t6_leftover", tdata, 32'hD002_0000);
        tick();
        chk("t6_beat2", tdata, 32'hE000_0000);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_tvalid", tvalid, 0);
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_done", done, 0);
        chk("t6_clr_in_ready", in_ready, 1);
        tick();
        chk("t6_clr_no_done", done, 0);
        start = 1'b1; len = 12'd1;
        tick();
        start = 1'b0;
        chk("t6_flushed_busy", busy, 1);
        chk("t6_flushed_tvalid", tvalid, 0);
        tready = 1'b0;
        push_word(16'hF000);
        chk("t6_pre_rst_tdata", tdata, 32'hF000_0000);
        chk("t6_pre_rst_tlast", tlast, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_tdata", tdata, 0);
        chk("t6_rst_tlast", tlast, 0);
        chk("t6_rst_tstrb", tstrb, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t6_post_rst_tvalid", tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
